wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter between the ALU and MEM result paths and the single register-manager write port. Each source gets a one-entry holding slot with a valid/ok handshake. Age-ordered arbitration retires one result per cycle through a registered output stage with back-pressure from the register manager. It replaces direct ALU/MEM muxing at the write-back stage, so simultaneous results are no longer dropped.

## Interface
- xlen, 32, data width of results and write port

- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset; synchronous, active-high (1 = reset), sampled on rising edge of clk
- alu_res  input  xlen  ALU result data
- alu_rd  input  5  ALU destination register
- alu_res_v  input  1  ALU result valid
- alu_ok  output  1  ALU slot can accept; transfer when alu_res_v && alu_ok
- mem_res  input  xlen  MEM result data
- mem_rd  input  5  MEM destination register
- mem_res_v  input  1  MEM result valid
- mem_ok  output  1  MEM slot can accept; transfer when mem_res_v && mem_ok
- result  output  xlen  write data to register manager
- rd  output  5  write destination
- result_v  output  1  write valid
- result_ready  input  1  register manager accepts; write retires when result_v && result_ready

## Operation
- Slots: alu_slot and mem_slot, each {full, data, rd}. States EMPTY and FULL per slot.
  - EMPTY->FULL on source handshake.
  - FULL->EMPTY on grant with no same-cycle handshake.
  - FULL->FULL on grant plus same-cycle handshake (refill).
- alu_ok = !alu_full || alu_grant; mem_ok likewise. Both are combinational from registered state, grant and result_ready. They never depend on alu_res_v or mem_res_v.
- out_free = !result_v || result_ready. No grant when out_free = 0.
- Age flag alu_older (registered):
  - When both slots are full, the older slot is granted.
  - On capture into one slot while the other stays full and is not granted, the other slot is older.
  - If both slots capture in the same cycle, MEM is older (alu_older = 0).
  - When only one slot is full, that slot is granted.
- rd == 0 entries are granted and drained normally but do not load the output register. result_v is not raised for them, and the previous output contents are not disturbed.
- Output register loads {slot data, slot rd} with result_v = 1 on grant when out_free and rd != 0. It clears result_v when out_free and no loading grant occurs.
- Reset values: all slots EMPTY, alu_older = 0, result_v = 0, result = 0, rd = 0. Consequently alu_ok = mem_ok = 1 in the first cycle after reset.
- Reset mid-operation discards slot contents and any pending output. No write is emitted for discarded entries.

## Timing
- Latency: handshake in cycle t -> slot FULL in t+1 -> granted in t+1 if out_free -> result_v = 1 in t+2.
- Throughput: one write per cycle sustained while result_ready = 1. Each slot refills in the same cycle it is granted.
- Both sources valid every cycle with result_ready = 1: grants alternate by age. Each source gets one accept per 2 cycles, and neither starves.
- result_ready = 0: the output holds result, rd and result_v stable. No grant occurs. Each slot fills once, then its ok = 0.
- A held output retires in the cycle result_ready = 1. A new grant loads in that same cycle, so there are no bubbles.
- All outputs except alu_ok and mem_ok are registered.

## Test plan
- Reset: hold rst_n = 1 for 2 cycles with both valids high -> result_v = 0, rd = 0, alu_ok = mem_ok = 1 the cycle after release. No write of pre-reset data appears.
- Single ALU: alu_res = 0x1234, alu_rd = 5, one cycle, result_ready = 1 -> result_v = 1, result = 0x1234, rd = 5 exactly 2 cycles later, for 1 cycle only.
- Simultaneous arrival: ALU (0xA, rd 3) and MEM (0xB, rd 4) in the same cycle -> MEM written first (rd 4) in t+2, then ALU (rd 3) in t+3. Both ok signals show correct refill acceptance.
- Age order: MEM captured at t, ALU at t+1, output blocked until t+3 -> after release, MEM retires first, then ALU.
- Back-pressure: result_ready = 0 for 5 cycles with continuous ALU/MEM valids -> output stable. alu_ok and mem_ok drop after their slots fill. After release, 3 writes occur in 3 consecutive cycles with no data loss or duplication.
- rd = 0: ALU result with alu_rd = 0 between two MEM writes -> no result_v for it. The MEM writes are unaffected. The ALU slot frees, with alu_ok = 1 after the grant.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Write-back bus bundle: ALU and MEM result sources plus the register-manager write port.
// The arbiter takes the slave view; the surrounding pipeline and register manager drive the master view.
interface wb_arbiter_if #(
   parameter int xlen = 32
);
   logic [xlen-1:0] alu_res;
   logic [4:0]      alu_rd;
   logic            alu_res_v;
   logic            alu_ok;

   logic [xlen-1:0] mem_res;
   logic [4:0]      mem_rd;
   logic            mem_res_v;
   logic            mem_ok;

   logic [xlen-1:0] result;
   logic [4:0]      rd;
   logic            result_v;
   logic            result_ready;

   modport slave (
      input  alu_res, alu_rd, alu_res_v,
      output alu_ok,
      input  mem_res, mem_rd, mem_res_v,
      output mem_ok,
      output result, rd, result_v,
      input  result_ready
   );

   modport master (
      output alu_res, alu_rd, alu_res_v,
      input  alu_ok,
      output mem_res, mem_rd, mem_res_v,
      input  mem_ok,
      input  result, rd, result_v,
      output result_ready
   );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: one holding slot per source, age-ordered grant, registered write port.
// Writes to r0 are drained from their slot without disturbing the output register.
module wb_arbiter #(
   parameter int xlen = 32
) (
   input logic         clk,
   input logic         rst_n,
   wb_arbiter_if.slave bus
);
   localparam int ALU = 0;
   localparam int MEM = 1;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

   logic [xlen-1:0] src_res [2];
   logic [4:0]      src_rd  [2];
   logic [1:0]      src_v;

   logic [xlen-1:0] slot_data [2];
   logic [4:0]      slot_rd   [2];
   logic [1:0]      full;
   logic [1:0]      grant;
   logic [1:0]      ok;
   logic [1:0]      hs;

   logic            alu_older_reg;
   logic            out_free;
   logic [xlen-1:0] sel_data;
   logic [4:0]      sel_rd;
   logic            load;

   logic [xlen-1:0] result_reg;
   logic [4:0]      rd_reg;
   logic            result_v_reg;

   assign src_res[ALU] = bus.alu_res;
   assign src_rd[ALU]  = bus.alu_rd;
   assign src_v[ALU]   = bus.alu_res_v;
   assign src_res[MEM] = bus.mem_res;
   assign src_rd[MEM]  = bus.mem_rd;
   assign src_v[MEM]   = bus.mem_res_v;

   assign bus.alu_ok   = ok[ALU];
   assign bus.mem_ok   = ok[MEM];
   assign bus.result   = result_reg;
   assign bus.rd       = rd_reg;
   assign bus.result_v = result_v_reg;

   assign out_free = !result_v_reg || bus.result_ready;

   // A lone full slot always wins; with both full the age flag decides.
   always_comb begin
      grant      = 2'b00;
      grant[ALU] = out_free && full[ALU] && (!full[MEM] || alu_older_reg);
      grant[MEM] = out_free && full[MEM] && (!full[ALU] || !alu_older_reg);
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_slot
         slot_state_t     state_reg;
         logic [xlen-1:0] data_reg;
         logic [4:0]      rd_slot_reg;

         assign full[gi]      = (state_reg == FULL);
         assign ok[gi]        = !full[gi] || grant[gi];
         assign hs[gi]        = src_v[gi] && ok[gi];
         assign slot_data[gi] = data_reg;
         assign slot_rd[gi]   = rd_slot_reg;

         // A granted slot may be refilled in the same cycle, staying FULL.
         always_ff @(posedge clk) begin
            if (rst_n) begin
               state_reg   <= EMPTY;
               data_reg    <= '0;
               rd_slot_reg <= '0;
            end else begin
               case (state_reg)
                  EMPTY: begin
                     if (hs[gi]) begin
                        state_reg   <= FULL;
                        data_reg    <= src_res[gi];
                        rd_slot_reg <= src_rd[gi];
                     end
                  end
                  FULL: begin
                     if (hs[gi]) begin
                        data_reg    <= src_res[gi];
                        rd_slot_reg <= src_rd[gi];
                     end else if (grant[gi]) begin
                        state_reg <= EMPTY;
                     end
                  end
                  default: state_reg <= EMPTY;
               endcase
            end
         end
      end
   endgenerate

   // The slot that keeps an older entry becomes the older one; a simultaneous capture favours MEM.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         alu_older_reg <= 1'b0;
      end else if (hs[ALU] && hs[MEM]) begin
         alu_older_reg <= 1'b0;
      end else if (hs[ALU] && full[MEM] && !grant[MEM]) begin
         alu_older_reg <= 1'b0;
      end else if (hs[MEM] && full[ALU] && !grant[ALU]) begin
         alu_older_reg <= 1'b1;
      end
   end

   always_comb begin
      sel_data = grant[MEM] ? slot_data[MEM] : slot_data[ALU];
      sel_rd   = grant[MEM] ? slot_rd[MEM]   : slot_rd[ALU];
      load     = (|grant) && (sel_rd != 5'd0);
   end

   // Data and rd are left untouched when nothing loads so an r0 drain never disturbs them.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         result_v_reg <= 1'b0;
         result_reg   <= '0;
         rd_reg       <= '0;
      end else if (out_free) begin
         result_v_reg <= load;
         if (load) begin
            result_reg <= sel_data;
            rd_reg     <= sel_rd;
         end
      end
   end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an arrival-stamp reference model.
module tb_wb_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   wb_arbiter_if #(.xlen(32)) bus ();

   wb_arbiter #(.xlen(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: each slot remembers the cycle its entry arrived; the oldest stamp wins,
   // ties go to MEM. The output is a simple valid/data/rd register.
   bit          m_full  [2];
   logic [31:0] m_data  [2];
   logic [4:0]  m_rd    [2];
   int          m_stamp [2];
   bit          m_v;
   logic [31:0] m_res;
   logic [4:0]  m_dst;
   int          m_cyc;

   // DUT outputs sampled in the most recent cycle
   logic [31:0] s_res;
   logic [4:0]  s_rd;
   logic        s_v, s_aok, s_mok;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, want, $time);
      end
   endtask

   task automatic cycle(input bit r,
                        input bit av, input logic [31:0] ad, input logic [4:0] ar,
                        input bit mv, input logic [31:0] md, input logic [4:0] mr,
                        input bit rdy);
      int          g;
      bit          free;
      bit          okm [2];
      bit          vin [2];
      logic [31:0] din [2];
      logic [4:0]  rin [2];
      @(negedge clk);
      rst_n = r;
      bus.alu_res_v = av; bus.alu_res = ad; bus.alu_rd = ar;
      bus.mem_res_v = mv; bus.mem_res = md; bus.mem_rd = mr;
      bus.result_ready = rdy;
      #1;
      s_res = bus.result; s_rd = bus.rd; s_v = bus.result_v;
      s_aok = bus.alu_ok; s_mok = bus.mem_ok;

      free = !m_v || rdy;
      g = -1;
      if (free) begin
         if (m_full[0] && m_full[1]) g = (m_stamp[0] < m_stamp[1]) ? 0 : 1;
         else if (m_full[0]) g = 0;
         else if (m_full[1]) g = 1;
      end
      okm[0] = !m_full[0] || (g == 0);
      okm[1] = !m_full[1] || (g == 1);

      chk("result_v", {31'd0, s_v}, {31'd0, m_v});
      chk("result", s_res, m_res);
      chk("rd", {27'd0, s_rd}, {27'd0, m_dst});
      chk("alu_ok", {31'd0, s_aok}, {31'd0, okm[0]});
      chk("mem_ok", {31'd0, s_mok}, {31'd0, okm[1]});

      if (!r && s_v && rdy)
         $display("write rd=%0d data=0x%08h t=%0t", s_rd, s_res, $time);

      vin[0] = av; din[0] = ad; rin[0] = ar;
      vin[1] = mv; din[1] = md; rin[1] = mr;
      if (r) begin
         m_full[0] = 0; m_full[1] = 0;
         m_v = 0; m_res = '0; m_dst = '0;
      end else begin
         if (free) begin
            if (g >= 0 && m_rd[g] != 5'd0) begin
               m_v = 1; m_res = m_data[g]; m_dst = m_rd[g];
            end else begin
               m_v = 0;
            end
         end
         if (g >= 0) m_full[g] = 0;
         for (int s = 0; s < 2; s++) begin
            if (vin[s] && okm[s]) begin
               m_full[s] = 1; m_data[s] = din[s]; m_rd[s] = rin[s]; m_stamp[s] = m_cyc;
            end
         end
      end
      m_cyc++;
   endtask

   task automatic idle();
      cycle(0, 0, 32'd0, 5'd0, 0, 32'd0, 5'd0, 1);
   endtask

   initial begin
      logic [4:0] ar, mr;
      bus.alu_res_v = 0; bus.alu_res = '0; bus.alu_rd = '0;
      bus.mem_res_v = 0; bus.mem_res = '0; bus.mem_rd = '0;
      bus.result_ready = 1;
      for (int s = 0; s < 2; s++) begin
         m_full[s] = 0; m_data[s] = '0; m_rd[s] = '0; m_stamp[s] = 0;
      end
      m_v = 0; m_res = '0; m_dst = '0; m_cyc = 0;

      // Reset held with both sources valid
      cycle(1, 1, 32'hDEAD, 5'd1, 1, 32'hBEEF, 5'd2, 1);
      cycle(1, 1, 32'hDEAD, 5'd1, 1, 32'hBEEF, 5'd2, 1);
      idle();
      chk("rst_result_v", {31'd0, s_v}, 32'd0);
      chk("rst_rd", {27'd0, s_rd}, 32'd0);
      chk("rst_alu_ok", {31'd0, s_aok}, 32'd1);
      chk("rst_mem_ok", {31'd0, s_mok}, 32'd1);
      idle();
      chk("rst_no_write", {31'd0, s_v}, 32'd0);

      // Single ALU result: visible exactly two cycles later for one cycle
      cycle(0, 1, 32'h1234, 5'd5, 0, 32'd0, 5'd0, 1);
      idle();
      chk("single_early", {31'd0, s_v}, 32'd0);
      idle();
      chk("single_v", {31'd0, s_v}, 32'd1);
      chk("single_data", s_res, 32'h1234);
      chk("single_rd", {27'd0, s_rd}, 32'd5);
      idle();
      chk("single_once", {31'd0, s_v}, 32'd0);
      idle();

      // Simultaneous arrival: MEM first, then ALU
      cycle(0, 1, 32'hA, 5'd3, 1, 32'hB, 5'd4, 1);
      idle();
      chk("simul_alu_ok", {31'd0, s_aok}, 32'd0);
      chk("simul_mem_ok", {31'd0, s_mok}, 32'd1);
      idle();
      chk("simul_first_rd", {27'd0, s_rd}, 32'd4);
      chk("simul_first_data", s_res, 32'hB);
      idle();
      chk("simul_second_rd", {27'd0, s_rd}, 32'd3);
      chk("simul_second_v", {31'd0, s_v}, 32'd1);
      idle();
      idle();

      // Back-pressure for 5 cycles with continuous valids
      for (int i = 0; i < 5; i++)
         cycle(0, 1, 32'hA00 + i, 5'd10, 1, 32'hB00 + i, 5'd11, 0);
      chk("bp_alu_ok", {31'd0, s_aok}, 32'd0);
      chk("bp_mem_ok", {31'd0, s_mok}, 32'd0);
      chk("bp_hold_data", s_res, 32'hB00);
      cycle(0, 0, 32'd0, 5'd0, 0, 32'd0, 5'd0, 1);
      chk("bp_w1", s_res, 32'hB00);
      idle();
      chk("bp_w2", s_res, 32'hA00);
      chk("bp_w2_v", {31'd0, s_v}, 32'd1);
      idle();
      chk("bp_w3", s_res, 32'hB01);
      chk("bp_w3_v", {31'd0, s_v}, 32'd1);
      idle();
      chk("bp_drained", {31'd0, s_v}, 32'd0);
      idle();

      // ALU write to r0 between two MEM writes
      cycle(0, 0, 32'd0, 5'd0, 1, 32'h111, 5'd1, 1);
      cycle(0, 1, 32'h999, 5'd0, 0, 32'd0, 5'd0, 1);
      cycle(0, 0, 32'd0, 5'd0, 1, 32'h222, 5'd2, 1);
      chk("rd0_mem1", s_res, 32'h111);
      chk("rd0_alu_ok", {31'd0, s_aok}, 32'd1);
      idle();
      chk("rd0_no_v", {31'd0, s_v}, 32'd0);
      chk("rd0_kept_data", s_res, 32'h111);
      idle();
      chk("rd0_mem2", s_res, 32'h222);
      chk("rd0_mem2_rd", {27'd0, s_rd}, 32'd2);

      // Randomized traffic with occasional mid-run reset
      for (int i = 0; i < 3000; i++) begin
         ar = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         mr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         cycle($urandom_range(0, 199) == 0,
               $urandom_range(0, 2) != 0, $urandom, ar,
               $urandom_range(0, 2) != 0, $urandom, mr,
               $urandom_range(0, 3) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
